// File: rtl/fb_pkg.sv
// Shared framebuffer constants and types, common to the fill engine, the
// screen driver and the framebuffer RAM.
package fb_pkg;

  localparam int WIDTH    = 800;
  localparam int HEIGHT   = 480;
  localparam int FB_DEPTH = 384000;
  localparam int CIDX_W   = 4;
  localparam int ADDR_W   = 19;

  typedef logic [CIDX_W-1:0] pixel_t;
  typedef logic [ADDR_W-1:0] fb_addr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_FILL,
    ST_DONE
  } fill_state_t;

  // y*800 + x as (y<<9)+(y<<8)+(y<<5)+x, avoiding a multiplier.
  function automatic fb_addr_t row_addr(input logic [8:0] y, input logic [9:0] x);
    fb_addr_t w_y;
    w_y = {10'd0, y};
    return (w_y << 9) + (w_y << 8) + (w_y << 5) + {9'd0, x};
  endfunction

endpackage

// File: rtl/fb_clip.sv
// Clips a fill rectangle to the visible screen and computes the start address
// of its first row.
module fb_clip
  import fb_pkg::*;
(
  input  logic [9:0]        i_x0,
  input  logic [8:0]        i_y0,
  input  logic [9:0]        i_w,
  input  logic [8:0]        i_h,
  output logic [10:0]       o_wc,
  output logic [9:0]        o_hc,
  output logic              o_empty,
  output logic [ADDR_W-1:0] o_base
);

  logic [10:0] w_wrem;
  logic [9:0]  w_hrem;

  // Remainders wrap when the origin is off-screen; o_empty masks that case.
  assign w_wrem  = 11'(WIDTH) - {1'b0, i_x0};
  assign w_hrem  = 10'(HEIGHT) - {1'b0, i_y0};
  assign o_wc    = ({1'b0, i_w} < w_wrem) ? {1'b0, i_w} : w_wrem;
  assign o_hc    = ({1'b0, i_h} < w_hrem) ? {1'b0, i_h} : w_hrem;
  assign o_empty = (i_x0 >= 10'(WIDTH)) || (i_y0 >= 9'(HEIGHT)) ||
                   (i_w == 10'd0) || (i_h == 9'd0);
  assign o_base  = row_addr(i_y0, i_x0);

endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle-fill writer: streams one palette index per granted cycle into the
// framebuffer RAM, clipped to the screen.
//   state    | meaning
//   ST_IDLE  | waiting for a command, cmd_ready high
//   ST_SETUP | clip and base-address computation
//   ST_FILL  | issuing writes, one per fb_ready grant
//   ST_DONE  | one-cycle completion pulse
module fb_rect_fill
  import fb_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [9:0]        i_cmd_x0,
  input  logic [8:0]        i_cmd_y0,
  input  logic [9:0]        i_cmd_w,
  input  logic [8:0]        i_cmd_h,
  input  logic [CIDX_W-1:0] i_cmd_color,
  output logic              o_fb_we,
  input  logic              i_fb_ready,
  output logic [ADDR_W-1:0] o_fb_addr,
  output logic [CIDX_W-1:0] o_fb_data,
  output logic              o_busy,
  output logic              o_done
);

  fill_state_t r_state, w_next;

  logic [9:0]  r_x0, r_w;
  logic [8:0]  r_y0, r_h;
  pixel_t      r_color, r_data;
  logic [10:0] r_wc, r_col, w_wc;
  logic [9:0]  r_hc, r_row, w_hc;
  fb_addr_t    r_row_base, r_addr, w_base;
  logic        r_we, r_done, w_empty, w_grant, w_last_col, w_last_row;

  fb_clip u_clip (
    .i_x0    (r_x0),
    .i_y0    (r_y0),
    .i_w     (r_w),
    .i_h     (r_h),
    .o_wc    (w_wc),
    .o_hc    (w_hc),
    .o_empty (w_empty),
    .o_base  (w_base)
  );

  assign w_grant    = r_we && i_fb_ready;
  assign w_last_col = (r_col == r_wc - 11'd1);
  assign w_last_row = (r_row == r_hc - 10'd1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_cmd_valid) w_next = ST_SETUP;
      ST_SETUP: w_next = w_empty ? ST_DONE : ST_FILL;
      ST_FILL:  if (w_grant && w_last_col && w_last_row) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_we       <= 1'b0;
      r_done     <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_row_base <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_wc       <= '0;
      r_hc       <= '0;
      r_x0       <= '0;
      r_y0       <= '0;
      r_w        <= '0;
      r_h        <= '0;
      r_color    <= '0;
    end else begin
      r_we   <= (w_next == ST_FILL);
      r_done <= (w_next == ST_DONE);
      if (r_state == ST_IDLE && i_cmd_valid) begin
        r_x0    <= i_cmd_x0;
        r_y0    <= i_cmd_y0;
        r_w     <= i_cmd_w;
        r_h     <= i_cmd_h;
        r_color <= i_cmd_color;
      end
      if (r_state == ST_SETUP) begin
        r_wc       <= w_wc;
        r_hc       <= w_hc;
        r_row_base <= w_base;
        r_addr     <= w_base;
        r_data     <= r_color;
        r_col      <= '0;
        r_row      <= '0;
      end
      // The final write leaves the address where it was so it never leaves the screen.
      if (r_state == ST_FILL && w_grant) begin
        if (!w_last_col) begin
          r_col  <= r_col + 11'd1;
          r_addr <= r_addr + 19'd1;
        end else if (!w_last_row) begin
          r_col      <= '0;
          r_row      <= r_row + 10'd1;
          r_row_base <= r_row_base + 19'(WIDTH);
          r_addr     <= r_row_base + 19'(WIDTH);
        end
      end
    end
  end

  assign o_cmd_ready = (r_state == ST_IDLE);
  assign o_busy      = !o_cmd_ready;
  assign o_fb_we     = r_we;
  assign o_fb_addr   = r_addr;
  assign o_fb_data   = r_data;
  assign o_done      = r_done;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed bench for fb_rect_fill: each command is driven, its write stream
// collected, and compared against hand-computed rectangles.
module tb_fb_rect_fill;

  logic        clk = 1'b0;
  logic        i_rst, i_cmd_valid, i_fb_ready;
  logic [9:0]  i_cmd_x0, i_cmd_w;
  logic [8:0]  i_cmd_y0, i_cmd_h;
  logic [3:0]  i_cmd_color;
  logic        o_cmd_ready, o_fb_we, o_busy, o_done;
  logic [18:0] o_fb_addr;
  logic [3:0]  o_fb_data;

  int n_tests = 0;
  int n_fail  = 0;

  int q_addr[$];
  int q_data[$];
  int acc_cyc, first_we, last_we, done_cyc, n_done, hold_err;
  int we_after_rst, rdy_after_rst, post_we, rdy_after;

  always #5 clk = ~clk;

  fb_rect_fill dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_x0    (i_cmd_x0),
    .i_cmd_y0    (i_cmd_y0),
    .i_cmd_w     (i_cmd_w),
    .i_cmd_h     (i_cmd_h),
    .i_cmd_color (i_cmd_color),
    .o_fb_we     (o_fb_we),
    .i_fb_ready  (i_fb_ready),
    .o_fb_addr   (o_fb_addr),
    .o_fb_data   (o_fb_data),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drives one command and collects its writes; rst_at>0 asserts reset in
  // that FILL cycle and then watches 20 idle cycles.
  task automatic run_cmd(input int x0, input int y0, input int w, input int h,
                         input int col, input bit rnd, input int rst_at, input int budget);
    int cyc, we_cycles, post, prev_addr, prev_data;
    bit fin, prev_stall, rst_phase;
    q_addr.delete();
    q_data.delete();
    acc_cyc = -1; first_we = -1; last_we = -1; done_cyc = -1;
    n_done = 0; hold_err = 0; post_we = 0; rdy_after = -1;
    we_after_rst = -1; rdy_after_rst = -1;
    cyc = 0; we_cycles = 0; post = 0; fin = 0; prev_stall = 0; rst_phase = 0;
    prev_addr = 0; prev_data = 0;
    @(posedge clk); #1;
    i_cmd_x0 = 10'(x0); i_cmd_y0 = 9'(y0); i_cmd_w = 10'(w); i_cmd_h = 9'(h);
    i_cmd_color = 4'(col); i_cmd_valid = 1'b1;
    i_fb_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while (!fin && cyc < budget) begin
      @(negedge clk);
      if (i_cmd_valid && o_cmd_ready && acc_cyc < 0) acc_cyc = cyc;
      if (rst_phase) begin
        post++;
        if (post == 1) begin
          we_after_rst = int'(o_fb_we);
          rdy_after_rst = int'(o_cmd_ready);
          i_rst = 1'b0;
        end
        if (o_fb_we) post_we++;
        if (o_done) n_done++;
        if (post == 20) fin = 1;
      end else begin
        if (prev_stall && (!o_fb_we || int'(o_fb_addr) != prev_addr || int'(o_fb_data) != prev_data))
          hold_err++;
        if (o_fb_we) begin
          we_cycles++;
          if (first_we < 0) first_we = cyc;
        end
        if (o_fb_we && i_fb_ready) begin
          q_addr.push_back(int'(o_fb_addr));
          q_data.push_back(int'(o_fb_data));
          last_we = cyc;
        end
        prev_stall = o_fb_we && !i_fb_ready;
        prev_addr = int'(o_fb_addr);
        prev_data = int'(o_fb_data);
        if (done_cyc >= 0 && cyc == done_cyc + 1) begin
          rdy_after = int'(o_cmd_ready);
          fin = 1;
        end
        if (o_done) begin
          n_done++;
          if (done_cyc < 0) done_cyc = cyc;
        end
        if (rst_at > 0 && o_fb_we && we_cycles == rst_at) begin
          i_rst = 1'b1;
          rst_phase = 1;
        end
      end
      cyc++;
      if (!fin) begin
        @(posedge clk); #1;
        if (acc_cyc >= 0) i_cmd_valid = 1'b0;
        if (rnd) i_fb_ready = 1'($urandom_range(0, 1));
      end
    end
    i_cmd_valid = 1'b0;
    i_fb_ready = 1'b1;
    if (!fin) chk("timeout", 32'd1, 32'd0);
  endtask

  task automatic check_rect(input string tag, input int x0, input int y0,
                            input int wc, input int hc, input int col);
    int errs;
    errs = 0;
    chk({tag, "_count"}, q_addr.size(), wc * hc);
    if (q_addr.size() == wc * hc) begin
      for (int r = 0; r < hc; r++)
        for (int c = 0; c < wc; c++)
          if (q_addr[r*wc+c] != (y0 + r) * 800 + x0 + c || q_data[r*wc+c] != col) errs++;
    end
    chk({tag, "_seq_errs"}, errs, 0);
    chk({tag, "_done_cnt"}, n_done, 1);
    chk({tag, "_done_after_last"}, done_cyc - last_we, 1);
    chk({tag, "_ready_after_done"}, rdy_after, 1);
  endtask

  initial begin
    int errs;
    i_rst = 1'b1; i_cmd_valid = 1'b0; i_fb_ready = 1'b1;
    i_cmd_x0 = '0; i_cmd_y0 = '0; i_cmd_w = '0; i_cmd_h = '0; i_cmd_color = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we", o_fb_we, 0);
    chk("rst_done", o_done, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ready", o_cmd_ready, 1);
    chk("rst_addr", o_fb_addr, 0);
    chk("rst_data", o_fb_data, 0);
    @(posedge clk); #1;
    i_rst = 1'b0;

    // Small rectangle, full grant
    run_cmd(10, 2, 3, 2, 14, 0, 0, 100);
    check_rect("small", 10, 2, 3, 2, 14);
    chk("small_first_we_lat", first_we - acc_cyc, 2);
    chk("small_span", last_we - first_we + 1, 6);
    if (q_addr.size() == 6) begin
      chk("small_a0", q_addr[0], 1610);
      chk("small_a3", q_addr[3], 2410);
      chk("small_a5", q_addr[5], 2412);
    end

    // Bottom-right clip
    run_cmd(798, 479, 5, 4, 3, 0, 0, 100);
    check_rect("clip", 798, 479, 2, 1, 3);
    if (q_addr.size() == 2) begin
      chk("clip_a0", q_addr[0], 383998);
      chk("clip_a1", q_addr[1], 383999);
    end

    // Empty commands
    run_cmd(5, 5, 0, 3, 7, 0, 0, 100);
    chk("empty_w_writes", first_we, -1);
    chk("empty_w_done_lat", done_cyc - acc_cyc, 2);
    chk("empty_w_done_cnt", n_done, 1);
    run_cmd(800, 10, 4, 4, 7, 0, 0, 100);
    chk("empty_x_writes", first_we, -1);
    chk("empty_x_done_lat", done_cyc - acc_cyc, 2);
    chk("empty_x_ready_after", rdy_after, 1);

    // Back-pressure on a 4x4 fill
    run_cmd(100, 50, 4, 4, 9, 1, 0, 400);
    check_rect("bp", 100, 50, 4, 4, 9);
    chk("bp_hold_errs", hold_err, 0);

    // Full-width band clipped at the bottom edge: rows 420..479
    run_cmd(0, 420, 800, 100, 0, 0, 0, 50000);
    chk("band_count", q_addr.size(), 48000);
    errs = 0;
    foreach (q_addr[i]) if (q_addr[i] != 336000 + i || q_data[i] != 0) errs++;
    chk("band_contig_errs", errs, 0);
    if (q_addr.size() > 0) chk("band_last", q_addr[q_addr.size()-1], 383999);
    chk("band_done_cnt", n_done, 1);
    chk("band_done_after_last", done_cyc - last_we, 1);
    chk("band_span", last_we - first_we + 1, 48000);

    // Reset in the 5th FILL cycle, then a normal command
    run_cmd(0, 0, 10, 3, 5, 0, 5, 200);
    chk("abort_we_next", we_after_rst, 0);
    chk("abort_ready", rdy_after_rst, 1);
    chk("abort_no_done", n_done, 0);
    chk("abort_no_more_we", post_we, 0);
    run_cmd(20, 1, 2, 2, 9, 0, 0, 100);
    check_rect("after_abort", 20, 1, 2, 2, 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
